switch_debouncer: RTL and testbench

// - Cleans raw slide-switch / push-button pins before they reach the switches PIO in_port.
// - Each bit gets a 2-flop synchroniser and a stability counter. sw_out is the debounced

---
 rtl/switch_debouncer.sv | 103 ++++++++++
 tb/tb_switch_debouncer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Per-bit debouncer for raw slide-switch / push-button pins.
//               Each bit passes through a 2-flop synchroniser, then a
//               stability counter. A new level is accepted only after it
//               has been seen on the synchronised input for STABLE_CYCLES
//               consecutive clocks.
//               sw_out carries the debounced levels. rise, fall and changed
//               are registered one-cycle strobes that fire in the same cycle
//               sw_out updates.
// Ports       : clk      - system clock, rising edge
//               reset    - asynchronous, active-high reset
//               sw_in    - raw asynchronous pin levels   [WIDTH]
//               sw_out   - debounced levels, registered  [WIDTH]
//               rise     - strobe, sw_out bit went 0->1  [WIDTH]
//               fall     - strobe, sw_out bit went 1->0  [WIDTH]
//               changed  - strobe, OR of all rise/fall bits
// Parameters  : WIDTH, STABLE_CYCLES (2 .. 2**CNT_BITS), CNT_BITS
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_BITS      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Terminal count: the edge that sees the counter at this value accepts
    // the new level, giving STABLE_CYCLES counting edges in total. Because
    // the counter is cleared here it never needs to hold STABLE_CYCLES.
    localparam logic [CNT_BITS-1:0] c_CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]    sync1_q,   sync1_d;
    logic [WIDTH-1:0]    sync2_q,   sync2_d;
    logic [WIDTH-1:0]    sw_out_q,  sw_out_d;
    logic [WIDTH-1:0]    rise_q,    rise_d;
    logic [WIDTH-1:0]    fall_q,    fall_d;
    logic                changed_q, changed_d;
    logic [CNT_BITS-1:0] cnt_q [WIDTH];
    logic [CNT_BITS-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d  = sw_in;
        sync2_d  = sync1_q;
        sw_out_d = sw_out_q;
        rise_d   = '0;
        fall_d   = '0;
        cnt_d    = cnt_q;

        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == sw_out_q[i]) begin
                // Input agrees with the accepted level: any partial
                // qualification (a glitch or bounce) is thrown away.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_CNT_LAST) begin
                sw_out_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync2_q[i];
                fall_d[i]   = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
            end
        end

        // Several bits qualifying together still yield one pulse.
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_out_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '{default: '0};
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sw_out_q  <= sw_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_out  = sw_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Scoreboard bench for switch_debouncer (WIDTH=8,
//               STABLE_CYCLES=4). The stimulus process drives sw_in one
//               cycle at a time and queues the hand-computed outputs for the
//               following clock edge; a monitor pops and compares after
//               every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int WIDTH = 8;

    typedef struct {
        string      tag;
        logic [7:0] o;
        logic [7:0] r;
        logic [7:0] f;
        logic       c;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    exp_t q[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (4),
        .CNT_BITS      (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    task automatic check_now(input string tag, input logic [7:0] eo, input logic [7:0] er,
                             input logic [7:0] ef, input logic ec);
        n_checks++;
        if ({sw_out, rise, fall, changed} !== {eo, er, ef, ec}) begin
            $display("FAIL %s: got sw_out=%h rise=%h fall=%h changed=%b, want sw_out=%h rise=%h fall=%h changed=%b",
                     tag, sw_out, rise, fall, changed, eo, er, ef, ec);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: every clock edge that has a queued expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now(e.tag, e.o, e.r, e.f, e.c);
            end
        end
    end

    // Drive one cycle of input and queue the outputs expected after the edge.
    task automatic cyc(input logic [7:0] in, input logic [7:0] eo, input logic [7:0] er,
                       input logic [7:0] ef, input logic ec, input string tag);
        exp_t e;
        @(negedge clk);
        sw_in = in;
        e.tag = tag; e.o = eo; e.r = er; e.f = ef; e.c = ec;
        q.push_back(e);
    endtask

    task automatic hold(input logic [7:0] in, input int n, input logic [7:0] eo, input string tag);
        for (int k = 0; k < n; k++) cyc(in, eo, 8'h00, 8'h00, 1'b0, tag);
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        sw_in = 8'hFF;

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #1 check_now("reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) sw_in = 8'h00;
        @(negedge clk) reset = 1'b0;

        // Glitch: 3 cycles reach count 3 but never the accept edge.
        hold(8'h08, 3, 8'h00, "glitch");
        hold(8'h00, 8, 8'h00, "glitch_after");

        // Clean rising edge: accepted on edge 6.
        hold(8'h01, 5, 8'h00, "clean_wait");
        cyc (8'h01, 8'h01, 8'h01, 8'h00, 1'b1, "clean_rise");
        hold(8'h01, 3, 8'h01, "clean_hold");

        // Clean falling edge.
        hold(8'h00, 5, 8'h01, "fall_wait");
        cyc (8'h00, 8'h00, 8'h00, 8'h01, 1'b1, "clean_fall");
        hold(8'h00, 2, 8'h00, "fall_hold");

        // Bounce 1,0,1,1...: rise 6 edges after the final 0->1.
        cyc (8'h01, 8'h00, 8'h00, 8'h00, 1'b0, "bounce_wait");
        cyc (8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "bounce_wait");
        hold(8'h01, 5, 8'h00, "bounce_wait");
        cyc (8'h01, 8'h01, 8'h01, 8'h00, 1'b1, "bounce_rise");
        hold(8'h01, 2, 8'h01, "bounce_hold");

        // Reach 0F, then swap to F0 in one step.
        hold(8'h0F, 5, 8'h01, "to0f_wait");
        cyc (8'h0F, 8'h0F, 8'h0E, 8'h00, 1'b1, "to0f_rise");
        hold(8'h0F, 2, 8'h0F, "to0f_hold");
        hold(8'hF0, 5, 8'h0F, "multi_wait");
        cyc (8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1, "multi_swap");
        hold(8'hF0, 2, 8'hF0, "multi_hold");

        // Reset one edge before bits 6..4 would fall; bit 7 must then
        // re-qualify from scratch.
        hold(8'h80, 5, 8'hF0, "midcount_pre");
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_now("midcount_reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        e.tag = "requalify_wait"; e.o = 8'h00; e.r = 8'h00; e.f = 8'h00; e.c = 1'b0;
        q.push_back(e);
        hold(8'h80, 4, 8'h00, "requalify_wait");
        cyc (8'h80, 8'h80, 8'h80, 8'h00, 1'b1, "requalify_rise");
        hold(8'h80, 2, 8'h80, "requalify_hold");

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) $display("FAIL scoreboard_drain: %0d left, want 0", q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
